onehot_mux_scan: RTL
====================

# onehot_mux_scan

Parametrised, registered one-hot multiplexer with an optional auto-scan mode. It selects one of `N` channels of `W` bits each and drives a registered output plus validity and index flags. Selection comes either from an external one-hot select, or from an internal round-robin pointer that dwells `DWELL` cycles per enabled channel. The block is the general data selector between register/time sources and the display formatting path, and replaces the fixed 6-to-1, 8-bit selector.

## Interface
- `W`, 8, data width per channel (≥1)
- `N`, 6, channel count (≥2)
- `DWELL`, 4, scan-mode cycles spent on each channel (≥1)

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `data_in`  input  N*W  channel i at `data_in[i*W +: W]`
- `sel`  input  N  one-hot manual select; `sel[i]` selects channel i
- `mode`  input  1  0 = manual, 1 = scan
- `ch_en`  input  N  scan-mode channel enable mask
- `err_clr`  input  1  clears `sel_err`
- `y`  output  W  registered selected data
- `y_valid`  output  1  `y` holds a selected channel's data
- `ch_idx`  output  clog2(N)  index of the channel in `y`
- `sel_err`  output  1  sticky flag: multi-hot `sel` seen in manual mode
- `scan_tick`  output  1  one-cycle pulse when the scan pointer advances

## Operation
- Reset (async, `rst_n`=0): `y`=0, `y_valid`=0, `ch_idx`=0, `sel_err`=0, `scan_tick`=0. Internal `ptr`=0 and dwell counter `cnt`=0.
- Manual mode (`mode`=0), evaluated every clock edge:
  - `sel` all zero: `y`←0, `y_valid`←0, `ch_idx`←0.
  - Exactly one bit `i` set: `y`←channel i, `y_valid`←1, `ch_idx`←i.
  - Two or more bits set: `y`, `y_valid` and `ch_idx` hold their previous values, and `sel_err`←1.
- `sel_err` stays set until a cycle with `err_clr`=1. If `err_clr` and a new multi-hot `sel` occur in the same cycle, set wins.
- Scan mode (`mode`=1):
  - Each cycle: `y`←channel `ptr`, `y_valid`←1, `ch_idx`←`ptr`. Data is live, so a change on the current channel appears one cycle later.
  - `cnt` increments every cycle. When `cnt`=DWELL-1: `cnt`←0, `ptr`←next enabled channel above `ptr` (wrapping N-1→0), and `scan_tick`←1 for one cycle.
  - If only one channel is enabled, `ptr` stays on it but `scan_tick` still pulses every DWELL cycles.
  - If `ch_en[ptr]` drops to 0 mid-dwell, on the next edge `ptr`←next enabled channel, `cnt`←0 and `scan_tick`←1.
  - If `ch_en` is all zero: `y`←0, `y_valid`←0, `cnt` held at 0, `ptr` held, no ticks.
- Mode 0→1 (sampled at an edge): `ptr`←lowest enabled channel and `cnt`←0 on that edge. Output follows scan rules from the next edge.
- Mode 1→0: manual rules apply from that edge. `ptr` and `cnt` freeze.
- In scan mode `sel` is ignored and `sel_err` does not set; `err_clr` still clears it.
- Reset asserted mid-scan or mid-error: all state returns to reset values immediately. After release the block restarts in whatever `mode` is presented.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency: 1 cycle from `sel`/`data_in`/`mode` to `y`, `y_valid` and `ch_idx`.
- `scan_tick` is high in the same cycle that `ch_idx` first shows the new channel.
- Scan period with k enabled channels is k*DWELL cycles. With DWELL=1, `ptr` advances every cycle.
- The next-enabled search is a single-cycle rotate-priority encoder over N bits.

## Configuration
- `ONEHOT_MUX_SCAN_EN` defined: full behaviour as above.
- Not defined: the scan logic (`ptr`, `cnt`, enable search) is not built.
  - `mode` and `ch_en` are ignored, and the block always behaves in manual mode.
  - `scan_tick` is tied to 0.
  - The port list is identical in both builds.

## Test plan
- Reset and single-bit select: reset, then W=8, N=6, channels 0x11..0x66, `sel`=6'b000100 → one cycle later `y`=0x33, `y_valid`=1, `ch_idx`=2.
- Zero and multi-hot select: `sel`=0 → `y`=0, `y_valid`=0. Then `sel`=6'b000100 followed by 6'b000110 → `y` holds 0x33 and `sel_err`=1. `err_clr` pulse → `sel_err`=0. `err_clr` together with multi-hot → `sel_err` stays 1.
- Scan full mask: `mode`=1, `ch_en`=all ones, DWELL=4 → `ch_idx` reads 0,0,0,0,1,1,1,1,…,5, then wraps to 0. `scan_tick` pulses every 4 cycles.
- Scan sparse mask and mid-dwell disable: `ch_en`=6'b100101 → `ch_idx` sequence 0,2,5,0. Clearing `ch_en[2]` during the dwell on channel 2 → next cycle `ch_idx`=5 with `scan_tick`=1. `ch_en`=0 → `y_valid`=0 and `y`=0.
- Async reset mid-scan: drop `rst_n` between edges → `y`, `y_valid`, `ch_idx` and `sel_err` go to 0 immediately. After release, scan restarts at the lowest enabled channel.
- Macro off: with `mode`=1 and `ch_en`=all ones, the outputs track `sel` exactly as in manual mode, and `scan_tick` stays 0.

Source files
------------

// File: rtl/onehot_mux_scan.sv
// Registered one-hot N:1 selector with sticky multi-hot error flag and optional round-robin scan.
// Scan pointer, dwell counter and enable search exist only when ONEHOT_MUX_SCAN_EN is defined.
module onehot_mux_scan #(
    parameter int W     = 8,
    parameter int N     = 6,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       data_in,
    input  logic [N-1:0]         sel,
    input  logic                 mode,
    input  logic [N-1:0]         ch_en,
    input  logic                 err_clr,
    output logic [W-1:0]         y,
    output logic                 y_valid,
    output logic [$clog2(N)-1:0] ch_idx,
    output logic                 sel_err,
    output logic                 scan_tick
);

    localparam int IW = $clog2(N);

    logic [W-1:0]  chan [N];
    logic [IW-1:0] sel_idx;
    logic          sel_any;
    logic          sel_multi;
    logic          err_set;

    always_comb begin
        sel_idx   = '0;
        sel_any   = |sel;
        sel_multi = |(sel & (sel - N'(1)));
        for (int i = 0; i < N; i++) begin
            chan[i] = data_in[i*W +: W];
            if (sel[i]) sel_idx = IW'(i);
        end
    end

`ifdef ONEHOT_MUX_SCAN_EN
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [IW-1:0] ptr, ptr_nxt, ptr_adv, ptr_low, cand;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mode_q;
    logic          tick_nxt;
    logic          found;

    // Rotate-priority search: offsets 1..N above ptr, so a lone enabled channel finds itself.
    always_comb begin
        ptr_adv = ptr;
        ptr_low = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && ch_en[cand]) begin
                found   = 1'b1;
                ptr_adv = cand;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (ch_en[i]) ptr_low = IW'(i);
        end
    end

    always_comb begin
        ptr_nxt  = ptr;
        cnt_nxt  = cnt;
        tick_nxt = 1'b0;
        if (!mode_q) begin
            if (|ch_en) ptr_nxt = ptr_low;
            cnt_nxt = '0;
        end else if (ch_en == '0) begin
            cnt_nxt = '0;
        end else if (!ch_en[ptr] || cnt == CW'(DWELL - 1)) begin
            ptr_nxt  = ptr_adv;
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Pointer and counter freeze while in manual mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            scan_tick <= 1'b0;
        end else begin
            mode_q    <= mode;
            scan_tick <= mode & tick_nxt;
            if (mode) begin
                ptr <= ptr_nxt;
                cnt <= cnt_nxt;
            end
        end
    end

    assign err_set = sel_multi & ~mode;
`else
    localparam int unused_dwell = DWELL;
    wire unused_scan = ^{mode, ch_en};

    assign scan_tick = 1'b0;
    assign err_set   = sel_multi;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            ch_idx  <= '0;
        end else begin
`ifdef ONEHOT_MUX_SCAN_EN
            if (mode) begin
                if (|ch_en) begin
                    y       <= chan[ptr_nxt];
                    y_valid <= 1'b1;
                    ch_idx  <= ptr_nxt;
                end else begin
                    y       <= '0;
                    y_valid <= 1'b0;
                    ch_idx  <= '0;
                end
            end else
`endif
            if (!sel_any) begin
                y       <= '0;
                y_valid <= 1'b0;
                ch_idx  <= '0;
            end else if (!sel_multi) begin
                y       <= chan[sel_idx];
                y_valid <= 1'b1;
                ch_idx  <= sel_idx;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sel_err <= 1'b0;
        else if (err_set) sel_err <= 1'b1;
        else if (err_clr) sel_err <= 1'b0;
    end

endmodule
